// File: rtl/flash_req_arbiter.sv
// flash_req_arbiter: shares one SPI flash read port between icache and dcache.
// dcache wins ties, but after STARVE_MAX back-to-back dcache grants with icache
// waiting, icache is forced through. One flash word per grant, with range
// check, timeout, cancel and a 2-cycle quiet gap after every transaction.
module flash_req_arbiter #(
   parameter int                ADDR_W     = 20,
   parameter int                DATA_W     = 32,
   parameter logic [ADDR_W-1:0] ADDR_LIMIT = 20'hAFFFF,
   parameter int                TIMEOUT    = 255,
   parameter int                STARVE_MAX = 4
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ready,
   output logic              i_err,
   input  logic              d_req,
   input  logic [ADDR_W-1:0] d_addr,
   output logic              d_ready,
   output logic              d_err,
   output logic [DATA_W-1:0] rdata,
   output logic              flash_req,
   output logic [ADDR_W-1:0] flash_addr,
   input  logic              flash_ready,
   input  logic [DATA_W-1:0] flash_data,
   output logic [1:0]        grant,
   output logic              busy
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int SW = $clog2(STARVE_MAX + 1);

   localparam logic [1:0] G_NONE = 2'b00;
   localparam logic [1:0] G_D    = 2'b01;
   localparam logic [1:0] G_I    = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_RESP,
      S_ERR,
      S_GAP
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        grant_q, grant_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [TW-1:0]     tcnt_q, tcnt_d;
   logic [SW-1:0]     starve_q, starve_d;
   logic              gap_q, gap_d;

   logic              own_req;
   logic              new_grant;
   logic [ADDR_W-1:0] sel_addr;

   // Next-state: arbitration in IDLE, flash handshake in ISSUE, response, gap.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      addr_d    = addr_q;
      rdata_d   = rdata_q;
      tcnt_d    = tcnt_q;
      starve_d  = starve_q;
      gap_d     = gap_q;
      new_grant = 1'b0;
      sel_addr  = '0;
      own_req   = grant_q[1] ? i_req : d_req;

      case (state_q)
         S_IDLE: begin
            if (i_req && (!d_req || starve_q == SW'(STARVE_MAX))) begin
               new_grant = 1'b1;
               grant_d   = G_I;
               sel_addr  = i_addr;
               starve_d  = '0;
            end else if (d_req) begin
               new_grant = 1'b1;
               grant_d   = G_D;
               sel_addr  = d_addr;
               if (!i_req)
                  starve_d = '0;
               else if (starve_q != SW'(STARVE_MAX))
                  starve_d = starve_q + 1'b1;
            end
            if (new_grant) begin
               addr_d = sel_addr;
               tcnt_d = '0;
               if (sel_addr > ADDR_LIMIT) begin
                  rdata_d = '0;
                  state_d = S_ERR;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            // Cancel beats a same-cycle flash_ready; the word is discarded.
            if (!own_req) begin
               grant_d = G_NONE;
               gap_d   = 1'b0;
               state_d = S_GAP;
            end else if (flash_ready) begin
               rdata_d = flash_data;
               state_d = S_RESP;
            end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
               rdata_d = '0;
               state_d = S_ERR;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         S_RESP, S_ERR: begin
            grant_d = G_NONE;
            gap_d   = 1'b0;
            state_d = S_GAP;
         end
         S_GAP: begin
            if (gap_q)
               state_d = S_IDLE;
            else
               gap_d = 1'b1;
         end
         default: begin
            grant_d = G_NONE;
            state_d = S_IDLE;
         end
      endcase
   end

   // State register; reset mid-transaction simply abandons it.
   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q  <= S_IDLE;
         grant_q  <= G_NONE;
         addr_q   <= '0;
         rdata_q  <= '0;
         tcnt_q   <= '0;
         starve_q <= '0;
         gap_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         addr_q   <= addr_d;
         rdata_q  <= rdata_d;
         tcnt_q   <= tcnt_d;
         starve_q <= starve_d;
         gap_q    <= gap_d;
      end
   end

   // Outputs decode straight from registered state, so they are glitch-free.
   always_comb begin
      flash_req  = (state_q == S_ISSUE);
      flash_addr = addr_q;
      rdata      = rdata_q;
      grant      = grant_q;
      busy       = (state_q != S_IDLE);
      i_ready    = ((state_q == S_RESP) || (state_q == S_ERR)) && (grant_q == G_I);
      d_ready    = ((state_q == S_RESP) || (state_q == S_ERR)) && (grant_q == G_D);
      i_err      = (state_q == S_ERR) && (grant_q == G_I);
      d_err      = (state_q == S_ERR) && (grant_q == G_D);
   end

endmodule

// File: tb/tb_flash_req_arbiter.sv
// Directed bench for flash_req_arbiter. Stimulus pushes expected responses
// into a queue; a negedge monitor pops one per ready pulse and compares.
module tb_flash_req_arbiter;

   logic        CLK = 1'b0;
   logic        reset;
   logic        i_req, d_req;
   logic [19:0] i_addr, d_addr;
   logic        i_ready, i_err, d_ready, d_err;
   logic [31:0] rdata;
   logic        flash_req;
   logic [19:0] flash_addr;
   logic        flash_ready;
   logic [31:0] flash_data;
   logic [1:0]  grant;
   logic        busy;

   typedef struct {
      logic        to_i;
      logic        err;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   npass = 0;
   int   ntotal = 0;

   always #5 CLK = ~CLK;

   flash_req_arbiter dut (
      .CLK(CLK), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_err(i_err),
      .d_req(d_req), .d_addr(d_addr), .d_ready(d_ready), .d_err(d_err),
      .rdata(rdata), .flash_req(flash_req), .flash_addr(flash_addr),
      .flash_ready(flash_ready), .flash_data(flash_data),
      .grant(grant), .busy(busy)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      ntotal++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic push(input logic to_i, input logic err, input logic [31:0] data);
      exp_t e;
      e.to_i = to_i;
      e.err  = err;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic wait_flash_req(input string nm, input int max);
      int n = 0;
      while (!flash_req && n < max) begin
         tick();
         n++;
      end
      if (!flash_req) chk({nm, "_flash_req_timeout"}, 0, 1);
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (busy && n < 20) begin
         tick();
         n++;
      end
      if (busy) chk({nm, "_idle_timeout"}, 1, 0);
   endtask

   task automatic pulse(input logic [31:0] v);
      flash_ready = 1'b1;
      flash_data  = v;
      tick();
      flash_ready = 1'b0;
      flash_data  = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Response monitor: every ready pulse must match the oldest expectation.
   always @(negedge CLK) begin
      if (i_ready || d_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_resp", {i_ready, d_ready}, 2'b00);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("resp_owner", {i_ready, d_ready}, e.to_i ? 2'b10 : 2'b01);
            chk("resp_err", e.to_i ? i_err : d_err, e.err);
            chk("resp_data", rdata, e.data);
         end
      end
   end

   initial begin
      int   cnt;
      logic saw;
      reset = 1'b1; i_req = 0; d_req = 0; i_addr = 0; d_addr = 0;
      flash_ready = 0; flash_data = 0;
      tick();
      tick();
      // Reset state
      chk("rst_outputs", {flash_req, flash_addr, i_ready, d_ready, i_err, d_err, grant, busy}, '0);
      chk("rst_rdata", rdata, 0);
      reset = 1'b0;

      // 1: basic dcache read
      d_req = 1; d_addr = 20'h00123;
      wait_flash_req("t1", 10);
      chk("t1_flash_addr", flash_addr, 20'h00123);
      chk("t1_grant", grant, 2'b01);
      push(1'b0, 1'b0, 32'hDEADBEEF);
      repeat (39) tick();
      chk("t1_still_req", flash_req, 1);
      pulse(32'hDEADBEEF);
      chk("t1_latency", d_ready, 1);
      d_req = 0;
      tick(); tick(); tick();
      chk("t1_idle", busy, 0);
      chk("t1_rdata_held", rdata, 32'hDEADBEEF);

      // 3: out-of-range, then boundary address (rdata non-zero beforehand)
      i_req = 1; i_addr = 20'hB0000;
      tick();
      chk("t3_grant", grant, 2'b10);
      chk("t3_err_resp", {i_ready, i_err, d_ready, flash_req}, 4'b1100);
      chk("t3_rdata_zero", rdata, 0);
      push(1'b1, 1'b1, 32'h0);
      i_req = 0;
      saw = flash_req;
      tick(); saw |= flash_req;
      tick(); saw |= flash_req;
      tick();
      chk("t3_no_flash_req", saw, 0);
      chk("t3_idle", busy, 0);
      i_req = 1; i_addr = 20'hAFFFF;
      wait_flash_req("t3b", 10);
      chk("t3b_flash_addr", flash_addr, 20'hAFFFF);
      push(1'b1, 1'b0, 32'h12345678);
      tick();
      pulse(32'h12345678);
      i_req = 0;
      wait_idle("t3b");

      // 2: both held, anti-starvation order D,D,D,D,I repeating
      do_reset();
      i_req = 1; i_addr = 20'h00100; d_req = 1; d_addr = 20'h00200;
      for (int k = 0; k < 10; k++) begin
         logic to_i;
         to_i = (k % 5 == 4);
         wait_flash_req("t2", 20);
         chk("t2_grant", grant, to_i ? 2'b10 : 2'b01);
         chk("t2_flash_addr", flash_addr, to_i ? 20'h00100 : 20'h00200);
         push(to_i, 1'b0, 32'h1000 + k);
         pulse(32'h1000 + k);
      end
      i_req = 0; d_req = 0;
      wait_idle("t2");

      // 4: timeout
      d_req = 1; d_addr = 20'h00400;
      push(1'b0, 1'b1, 32'h0);
      wait_flash_req("t4", 10);
      cnt = 0;
      while (flash_req && cnt < 400) begin
         cnt++;
         tick();
      end
      chk("t4_req_cycles", cnt, 255);
      chk("t4_err_resp", {d_ready, d_err, rdata}, {2'b11, 32'h0});
      d_req = 0;
      tick();
      chk("t4_gap1", {busy, grant, flash_req}, 4'b1000);
      tick();
      chk("t4_gap2", {busy, grant, flash_req}, 4'b1000);
      tick();
      chk("t4_idle", busy, 0);

      // 5: cancel in the same cycle as flash_ready, pending dcache follows
      do_reset();
      i_req = 1; i_addr = 20'h00010;
      wait_flash_req("t5", 10);
      chk("t5_grant_i", grant, 2'b10);
      d_req = 1; d_addr = 20'h00020;
      tick(); tick();
      i_req = 0; flash_ready = 1; flash_data = 32'h0BAD0BAD;
      tick();
      flash_ready = 0; flash_data = 0;
      chk("t5_cyc1", {flash_req, i_ready, busy, grant}, 5'b00100);
      tick();
      chk("t5_cyc2", {flash_req, i_ready, busy, grant}, 5'b00100);
      tick();
      chk("t5_cyc3_idle", busy, 0);
      tick();
      chk("t5_d_grant", {grant, flash_req}, 3'b011);
      chk("t5_d_addr", flash_addr, 20'h00020);
      push(1'b0, 1'b0, 32'h5A5A0001);
      pulse(32'h5A5A0001);
      d_req = 0;
      wait_idle("t5");

      // 6: reset in ISSUE, request held through reset
      d_req = 1; d_addr = 20'h00055;
      wait_flash_req("t6", 10);
      tick(); tick(); tick();
      reset = 1;
      tick();
      chk("t6_abort", {flash_req, grant, busy, i_ready, d_ready}, '0);
      reset = 0;
      wait_flash_req("t6b", 10);
      chk("t6_flash_addr", flash_addr, 20'h00055);
      push(1'b0, 1'b0, 32'hCAFEF00D);
      pulse(32'hCAFEF00D);
      d_req = 0;
      wait_idle("t6");

      tick(); tick();
      chk("all_resp_seen", exp_q.size(), 0);
      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
